// File: rtl/pwm_cap_pkg.sv
// pwm_capture shared definitions
// register map, control bits, measurement states
package pwm_cap_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'b00;
  localparam logic [1:0] ADDR_PERIOD = 2'b01;
  localparam logic [1:0] ADDR_HIGH   = 2'b10;
  localparam logic [1:0] ADDR_EDGES  = 2'b11;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;
  localparam int CTRL_IRQ = 2;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    HIGH,
    LOW
  } state_e;

endpackage

// File: rtl/pwm_capture_sync.sv
// pwm_in_sync: 2-flop synchronizers for pwm/dir
// plus rise/fall detection on the synced pwm
module pwm_in_sync (
  input  logic clk,
  input  logic reset,
  input  logic pwm_in,
  input  logic dir_in,
  output logic pwm_s,
  output logic dir_s,
  output logic rise,
  output logic fall
);

  logic pwm_m_q, pwm_m_d;
  logic pwm_s_q, pwm_s_d;
  logic pwm_d_q, pwm_d_d;
  logic dir_m_q, dir_m_d;
  logic dir_s_q, dir_s_d;

  // shift chains: pin -> meta -> sync -> delayed
  always_comb begin
    pwm_m_d = pwm_in;
    pwm_s_d = pwm_m_q;
    pwm_d_d = pwm_s_q;
    dir_m_d = dir_in;
    dir_s_d = dir_m_q;
  end

  // sync flops, cleared by reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      pwm_m_q <= 1'b0;
      pwm_s_q <= 1'b0;
      pwm_d_q <= 1'b0;
      dir_m_q <= 1'b0;
      dir_s_q <= 1'b0;
    end else begin
      pwm_m_q <= pwm_m_d;
      pwm_s_q <= pwm_s_d;
      pwm_d_q <= pwm_d_d;
      dir_m_q <= dir_m_d;
      dir_s_q <= dir_s_d;
    end
  end

  assign pwm_s = pwm_s_q;
  assign dir_s = dir_s_q;
  assign rise  = pwm_s_q & ~pwm_d_q;
  assign fall  = ~pwm_s_q & pwm_d_q;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period/high time of an
// external PWM input, exposed on the register bus
module pwm_capture
  import pwm_cap_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int unsigned TIMEOUT = 'hffff
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        wr_n,
  input  logic [31:0] wrdata,
  input  logic        rd_n,
  output logic [31:0] rddata,
  input  logic        pwm_in,
  input  logic        dir_in,
  output logic        irq
);

  localparam logic [CNT_W-1:0] TO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] MAX = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic pwm_s, dir_s, rise, fall;

  pwm_in_sync u_sync (
    .clk    (clk),
    .reset  (reset),
    .pwm_in (pwm_in),
    .dir_in (dir_in),
    .pwm_s  (pwm_s),
    .dir_s  (dir_s),
    .rise   (rise),
    .fall   (fall)
  );

  state_e            state_q, state_d;
  logic              enable_q, enable_d;
  logic              irq_en_q, irq_en_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  hi_cnt_q, hi_cnt_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic [CNT_W-1:0]  high_q, high_d;
  logic [CNT_W-1:0]  edge_q, edge_d;
  logic              new_q, new_d;
  logic              stall_q, stall_d;
  logic              lvl_q, lvl_d;
  logic              dir_q, dir_d;
  logic [31:0]       rddata_q, rddata_d;

  logic              wr_ctrl, clr, cap, stl;
  logic              timeout;
  logic [CNT_W-1:0]  cnt_inc;
  logic              unused_wrdata;

  assign unused_wrdata = ^wrdata[31:3];

  // FSM, counters, capture, stall and bus access
  always_comb begin
    state_d  = state_q;
    enable_d = enable_q;
    irq_en_d = irq_en_q;
    cnt_d    = cnt_q;
    hi_cnt_d = hi_cnt_q;
    period_d = period_q;
    high_d   = high_q;
    edge_d   = edge_q;
    new_d    = new_q;
    stall_d  = stall_q;
    lvl_d    = lvl_q;
    dir_d    = dir_q;
    rddata_d = rddata_q;
    cap      = 1'b0;
    stl      = 1'b0;
    wr_ctrl  = !wr_n && (addr == ADDR_CTRL);
    clr      = wr_ctrl && wrdata[CTRL_CLR];
    timeout  = cnt_q >= TO;
    cnt_inc  = (cnt_q == MAX) ? cnt_q
                              : cnt_q + ONE;

    if (!enable_q) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = ARM;
          cnt_d   = '0;
        end
        ARM: begin
          if (rise) begin
            state_d = HIGH;
            cnt_d   = ONE;
          end else if (fall) begin
            cnt_d = '0;
          end else if (timeout) begin
            stl = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        HIGH: begin
          if (fall) begin
            state_d  = LOW;
            hi_cnt_d = cnt_q;
            cnt_d    = cnt_inc;
          end else if (timeout) begin
            stl = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        LOW: begin
          if (rise) begin
            cap     = 1'b1;
            state_d = HIGH;
            cnt_d   = ONE;
          end else if (timeout) begin
            stl = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      endcase
    end

    if (stl) begin
      state_d  = ARM;
      cnt_d    = '0;
      stall_d  = 1'b1;
      lvl_d    = pwm_s;
      period_d = '0;
      high_d   = '0;
      new_d    = 1'b1;
    end

    if (cap) begin
      period_d = cnt_q;
      high_d   = hi_cnt_q;
      dir_d    = dir_s;
      new_d    = 1'b1;
      stall_d  = 1'b0;
      edge_d   = edge_q + ONE;
    end

    if (!rd_n) begin
      unique case (addr)
        ADDR_CTRL:
          rddata_d = {26'b0, lvl_q, stall_q,
                      dir_q, new_q, irq_en_q,
                      enable_q};
        ADDR_PERIOD: rddata_d = 32'(period_q);
        ADDR_HIGH:   rddata_d = 32'(high_q);
        ADDR_EDGES:  rddata_d = 32'(edge_q);
      endcase
      if (addr == ADDR_PERIOD && !cap && !stl)
        new_d = 1'b0;
    end

    if (wr_ctrl) begin
      enable_d = wrdata[CTRL_EN];
      irq_en_d = wrdata[CTRL_IRQ];
    end

    if (clr) begin
      period_d = '0;
      high_d   = '0;
      edge_d   = '0;
      new_d    = 1'b0;
      stall_d  = 1'b0;
      if (wrdata[CTRL_EN]) begin
        state_d = ARM;
        cnt_d   = '0;
      end
    end
  end

  // state registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      enable_q <= 1'b0;
      irq_en_q <= 1'b0;
      cnt_q    <= '0;
      hi_cnt_q <= '0;
      period_q <= '0;
      high_q   <= '0;
      edge_q   <= '0;
      new_q    <= 1'b0;
      stall_q  <= 1'b0;
      lvl_q    <= 1'b0;
      dir_q    <= 1'b0;
      rddata_q <= '0;
    end else begin
      state_q  <= state_d;
      enable_q <= enable_d;
      irq_en_q <= irq_en_d;
      cnt_q    <= cnt_d;
      hi_cnt_q <= hi_cnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      edge_q   <= edge_d;
      new_q    <= new_d;
      stall_q  <= stall_d;
      lvl_q    <= lvl_d;
      dir_q    <= dir_d;
      rddata_q <= rddata_d;
    end
  end

  assign rddata = rddata_q;
  assign irq    = new_q & irq_en_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: randomized pin/bus stimulus,
// timestamp reference model, read scoreboard
module tb_pwm_capture;

  localparam int TO = 20;
  localparam int M_IDLE = 0;
  localparam int M_ARM  = 1;
  localparam int M_HIGH = 2;
  localparam int M_LOW  = 3;

  logic        clk, reset, wr_n, rd_n;
  logic        pwm_in, dir_in, irq;
  logic [1:0]  addr;
  logic [31:0] wrdata, rddata;

  pwm_capture #(.CNT_W(16), .TIMEOUT(TO)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .wr_n   (wr_n),
    .wrdata (wrdata),
    .rd_n   (rd_n),
    .rddata (rddata),
    .pwm_in (pwm_in),
    .dir_in (dir_in),
    .irq    (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0]  a;
    logic [31:0] v;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  int n_tests, n_fail;
  bit mon_on, mon_rd;

  bit          b_rst, b_wr, b_rd, b_pwm, b_dir;
  logic [1:0]  b_addr;
  logic [31:0] b_wd;

  int t;
  int m_mode, m_r, m_aref, m_hi;
  int m_per, m_high, m_edges;
  bit m_en, m_irqen, m_new, m_stall, m_lvl, m_dir;
  bit m_p1, m_ps, m_pd, m_d1, m_ds, m_irq;

  function automatic logic [31:0] m_read(
    logic [1:0] a);
    case (a)
      2'd0: m_read = {26'b0, m_lvl, m_stall, m_dir,
                      m_new, m_irqen, m_en};
      2'd1: m_read = 32'(m_per);
      2'd2: m_read = 32'(m_high);
      default: m_read = 32'(m_edges);
    endcase
  endfunction

  // reference: timestamps of last rise / arm start
  task automatic model_step();
    bit rise, fall, cap, stl;
    int nm, since, idle;
    t++;
    if (b_rst) begin
      m_mode = M_IDLE; m_r = 0; m_aref = 0;
      m_hi = 0; m_per = 0; m_high = 0;
      m_edges = 0; m_en = 0; m_irqen = 0;
      m_new = 0; m_stall = 0; m_lvl = 0;
      m_dir = 0; m_p1 = 0; m_ps = 0; m_pd = 0;
      m_d1 = 0; m_ds = 0; m_irq = 0;
      return;
    end
    rise = m_ps && !m_pd;
    fall = !m_ps && m_pd;
    cap = 0; stl = 0; nm = m_mode;
    since = t - m_r;
    idle = t - m_aref;
    if (b_rd)
      exp_q.push_back('{b_addr, m_read(b_addr)});
    if (!m_en) nm = M_IDLE;
    else case (m_mode)
      M_IDLE: begin nm = M_ARM; m_aref = t + 1; end
      M_ARM:
        if (rise) begin nm = M_HIGH; m_r = t; end
        else if (fall) m_aref = t + 1;
        else if (idle >= TO) stl = 1;
      M_HIGH:
        if (fall) begin
          nm = M_LOW; m_hi = t - m_r;
        end else if (since >= TO) stl = 1;
      default:
        if (rise) begin
          cap = 1; m_per = t - m_r;
          m_high = m_hi; m_r = t; nm = M_HIGH;
        end else if (since >= TO) stl = 1;
    endcase
    if (stl) begin
      m_stall = 1; m_lvl = m_ps;
      m_per = 0; m_high = 0; m_new = 1;
      nm = M_ARM; m_aref = t + 1;
    end
    if (cap) begin
      m_dir = m_ds; m_new = 1; m_stall = 0;
      m_edges = (m_edges + 1) % 65536;
    end
    if (b_rd && b_addr == 2'd1 && !cap && !stl)
      m_new = 0;
    if (b_wr && b_addr == 2'd0) begin
      m_en = b_wd[0];
      m_irqen = b_wd[2];
      if (b_wd[1]) begin
        m_per = 0; m_high = 0; m_edges = 0;
        m_new = 0; m_stall = 0;
        if (b_wd[0]) begin
          nm = M_ARM; m_aref = t + 1;
        end
      end
    end
    m_mode = nm;
    m_pd = m_ps; m_ps = m_p1; m_p1 = b_pwm;
    m_ds = m_d1; m_d1 = b_dir;
    m_irq = m_new && m_irqen;
  endtask

  task automatic cycle();
    @(negedge clk);
    reset  = !b_rst;
    wr_n   = !b_wr;
    rd_n   = !b_rd;
    addr   = b_addr;
    wrdata = b_wd;
    pwm_in = b_pwm;
    dir_in = b_dir;
    model_step();
    b_wr = 0;
    b_rd = 0;
  endtask

  task automatic rnd_read();
    if ($urandom_range(0, 3) == 0) begin
      b_rd = 1;
      b_addr = 2'($urandom_range(0, 3));
    end
  endtask

  task automatic hold(int n);
    for (int i = 0; i < n; i++) begin
      rnd_read();
      cycle();
    end
  endtask

  task automatic periods(int hi, int lo, int n);
    for (int p = 0; p < n; p++)
      for (int i = 0; i < hi + lo; i++) begin
        b_pwm = (i < hi);
        rnd_read();
        cycle();
      end
  endtask

  task automatic rd(logic [1:0] a);
    b_rd = 1;
    b_addr = a;
    cycle();
  endtask

  task automatic rd_all();
    for (int a = 0; a < 4; a++) rd(2'(a));
  endtask

  task automatic wr(logic [1:0] a,
                    logic [31:0] d);
    b_wr = 1;
    b_addr = a;
    b_wd = d;
    cycle();
  endtask

  // monitor: irq every cycle, rddata after reads
  always @(posedge clk) begin
    rd_exp_t e;
    mon_rd = (rd_n == 1'b0) && (reset == 1'b1);
    #1;
    if (mon_on) begin
      n_tests++;
      if (irq !== m_irq) begin
        n_fail++;
        $display("FAIL irq t=%0d: got %b want %b",
                 t, irq, m_irq);
      end
      if (mon_rd) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rd_unexpected: got %h want none",
                   rddata);
        end else begin
          e = exp_q.pop_front();
          if (rddata !== e.v) begin
            n_fail++;
            $display("FAIL rd_addr%0d t=%0d: got %h want %h",
                     e.a, t, rddata, e.v);
          end
        end
      end
    end
  end

  initial begin
    reset = 0; wr_n = 1; rd_n = 1; addr = 0;
    wrdata = 0; pwm_in = 0; dir_in = 0;
    b_rst = 1; b_wr = 0; b_rd = 0; b_pwm = 0;
    b_dir = 0; b_addr = 0; b_wd = 0;
    n_tests = 0; n_fail = 0; t = 0; mon_on = 0;
    cycle();
    mon_on = 1;
    cycle();
    b_rst = 0;
    cycle();
    rd_all();

    // basic 3/5 measurement, dir high
    wr(2'd0, 32'h5);
    hold(2);
    b_dir = 1;
    periods(3, 5, 4);
    rd(2'd0); rd(2'd1); rd(2'd0);
    rd(2'd2); rd(2'd3);
    periods(3, 5, 2);
    rd(2'd0);

    // randomized shapes, ignored addresses
    for (int k = 0; k < 12; k++) begin
      b_dir = 1'($urandom_range(0, 1));
      periods($urandom_range(1, 9),
              $urandom_range(1, 9),
              $urandom_range(1, 4));
      wr(2'($urandom_range(1, 3)), $urandom);
      rd_all();
    end

    // stall with constant high, then recover
    b_pwm = 1;
    hold(30);
    rd(2'd0); rd(2'd1); rd(2'd2);
    periods(4, 4, 4);
    rd(2'd0); rd(2'd1); rd(2'd2);

    // disable mid-high, re-enable
    periods(4, 4, 2);
    b_pwm = 1;
    cycle(); cycle();
    wr(2'd0, 32'h0);
    periods(2, 3, 2);
    rd_all();
    wr(2'd0, 32'h5);
    periods(3, 4, 3);
    rd_all();

    // reset mid-low, capture needs re-enable
    periods(3, 5, 2);
    b_pwm = 0;
    cycle(); cycle();
    b_rst = 1;
    cycle();
    b_rst = 0;
    rd_all();
    periods(3, 5, 2);
    rd(2'd1); rd(2'd3);
    wr(2'd0, 32'h5);
    periods(3, 5, 3);
    rd_all();

    // enable+clear on the capture cycle
    periods(3, 5, 2);
    b_pwm = 1;
    cycle(); cycle();
    wr(2'd0, 32'h3);
    rd(2'd1); rd(2'd2); rd(2'd3); rd(2'd0);

    // write and read in the same cycle
    b_rd = 1;
    wr(2'd0, 32'h5);
    for (int k = 0; k < 6; k++) begin
      wr(2'd0, {29'b0, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'b1});
      periods($urandom_range(1, 8),
              $urandom_range(1, 8), 3);
      rd_all();
    end

    hold(3);
    b_rd = 0;
    cycle(); cycle();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rd_drain: got %0d left want 0",
               exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Read-side counterpart of the motor PWM generator: it samples an external PWM/direction pair and measures period and high time in clk cycles.
- Results are exposed to the soft CPU over the same 2-bit-address, active-low-strobe register bus the PWM generators use.
- Used for motor-driver loopback checking and for decoding PWM commands from external modules.

Parameters:
- CNT_W, 16, width of period/high counters and result registers.
- TIMEOUT, 16'hffff, cycles without an edge before the input is declared stalled; must be ≤ 2^CNT_W-1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-low reset (sampled on clk rising edge; one clock, reset is synchronous and active-low)
- addr  in  2  register address
- wr_n  in  1  write strobe, active low
- wrdata  in  32  write data
- rd_n  in  1  read strobe, active low
- rddata  out  32  read data, registered
- pwm_in  in  1  asynchronous PWM input
- dir_in  in  1  asynchronous direction input
- irq  out  1  high while new_flag=1 and irq_en=1

Behaviour:
- Reset (reset=0 at posedge): every register goes to 0 (enable, irq_en, state=IDLE, cnt, hi_cnt, period_r, high_r, new_flag, stall, stall_lvl, dir_r, edge_cnt); rddata=0, irq=0. Reset mid-measurement discards all partial counts.
- Input sync: pwm_in and dir_in pass through 2 flops each. rise = pwm_s & ~pwm_d; fall = ~pwm_s & pwm_d.
- FSM states:
  - IDLE: enable=0. Counters held, results held.
  - ARM: waiting for the first rise.
  - HIGH: counting high samples.
  - LOW: counting low samples.
- Transitions:
  - IDLE→ARM on enable 0→1.
  - ARM→HIGH on rise.
  - HIGH→LOW on fall.
  - LOW→HIGH on rise.
  - Any state→IDLE when enable=0.
- Counting:
  - On rise, cnt<=1.
  - Otherwise in HIGH/LOW, cnt<=cnt+1, saturating at 2^CNT_W-1.
  - On fall, hi_cnt<=cnt and cnt still increments.
  - On rise in LOW (a completed period):
    - period_r<=cnt, high_r<=hi_cnt, dir_r<=dir_s.
    - new_flag<=1, stall<=0.
    - edge_cnt<=edge_cnt+1, wrapping modulo 2^CNT_W.
- Latency: results update 3 clk after the pin edge (2 sync flops + 1 capture flop).
- Stall: in HIGH/LOW/ARM, if cnt (or the ARM idle counter) reaches TIMEOUT with no edge:
  - stall<=1, stall_lvl<=pwm_s.
  - period_r<=0, high_r<=0, new_flag<=1.
  - state→ARM.
  - A constant-high input is thus reported as stall=1, stall_lvl=1.
- Write (wr_n=0):
  - addr 00: enable<=wrdata[0], irq_en<=wrdata[2]. wrdata[1]=1 is a clear pulse: results, new_flag, stall and edge_cnt go to 0, and state→ARM if enabled.
  - Other addresses are ignored.
- Read (rd_n=0): rddata is valid on the next clk.
  - addr 00: {26'b0, stall_lvl, stall, dir_r, new_flag, irq_en, enable}.
  - addr 01: period_r zero-extended. This read clears new_flag.
  - addr 10: high_r zero-extended.
  - addr 11: edge_cnt zero-extended.
  - rddata holds its last value when rd_n=1.
- Simultaneous events:
  - Capture and addr-01 read in the same cycle: rddata returns the old period_r, and new_flag stays 1.
  - Clear write and capture in the same cycle: clear wins.
  - wr_n and rd_n both low: both actions occur.

Decomposition:
- Package pwm_cap_pkg:
  - Address constants ADDR_CTRL=2'b00, ADDR_PERIOD=2'b01, ADDR_HIGH=2'b10, ADDR_EDGES=2'b11.
  - Control bit indices.
  - State enum {IDLE, ARM, HIGH, LOW}.
- One sub-module, pwm_in_sync: 2-flop synchronizer for pwm/dir plus rise/fall detect, reset to 0.

Test Plan:
- Enable; drive pwm_in 3 cycles high / 5 low for 4 periods, dir_in=1 → period=8, high=3, ctrl reads new_flag=1, dir=1, edges=3 (first rise only arms).
- After capture, read addr 01 → returns 8. Next ctrl read shows new_flag=0; the following capture sets it again; irq follows new_flag when irq_en=1.
- TIMEOUT=20; hold pwm_in high 30 cycles → stall=1, stall_lvl=1, period=high=0. Resume 4/4 toggling → stall=0, period=8, high=4.
- Write ctrl=0 mid-HIGH, hold 10 cycles, then re-enable → results unchanged until two rises later; first result is clean (no stale cnt).
- Assert reset for 1 cycle mid-LOW → all reads return 0, irq=0; capture resumes only after enable is rewritten.
- Write ctrl=3'b011 (enable+clear) on the same cycle a capture is due → period=high=edges=0, new_flag=0.
